// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: 8-byte register window (DATA/STATUS/DIVISOR), 2^FIFO_LOG2-entry TX FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frames) and set the STATUS capability flag bit9.
module uart_tx_mmio #(
  parameter logic [15:0] BASE_ADDR = 16'hFE00,
  parameter logic [15:0] DIV_RESET = 16'd868,
  parameter int          FIFO_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        wr,
  input  logic        wide,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        sel_q,
  output logic        tx
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW    = FIFO_LOG2 + 1;
  localparam logic [CW-1:0]        CNT_ONE = CW'(1);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE = FIFO_LOG2'(1);

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_CAP = 1'b1;
`else
  localparam logic PARITY_CAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------- bus decode
  logic       hit;
  logic [1:0] reg_sel;
  logic       lane;
  logic [7:0] wr_byte;
  logic       push_req;
  logic       status_rd;
  logic       div_wr;

  assign hit       = en && (addr[15:3] == BASE_ADDR[15:3]);
  assign reg_sel   = addr[2:1];
  assign lane      = addr[0];
  assign wr_byte   = (!wide && lane) ? din[15:8] : din[7:0];
  assign push_req  = hit && wr && (reg_sel == 2'd0);
  assign status_rd = hit && !wr && (reg_sel == 2'd1);
  assign div_wr    = hit && wr && (reg_sel == 2'd2);

  // ---------------------------------------------------------------- FIFO
  // Internal handshake: push is a valid from the bus that completes when
  // the FIFO is not full or a pop happens in the same cycle; pop is issued
  // only by the FSM in IDLE and only while the FIFO is not empty.
  logic [7:0]           fifo_mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 full, empty, push, pop;
  logic                 ovf_q;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wr_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // A dropped push in the same cycle as a STATUS read keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (push_req && full && !pop) begin
      ovf_q <= 1'b1;
    end else if (status_rd) begin
      ovf_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- divisor
  logic [15:0] div_q, div_new;

  always_comb begin
    div_new = div_q;
    if (wide)      div_new = din;
    else if (lane) div_new[15:8] = din[15:8];
    else           div_new[7:0]  = din[7:0];
    if (div_new == 16'd0) div_new = 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       div_q <= DIV_RESET;
    else if (div_wr) div_q <= div_new;
  end

  // ---------------------------------------------------------------- TX FSM
  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] div_shadow_q, div_shadow_d;
  logic        tx_q, tx_d;
  logic        bit_done;
  logic        busy;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign bit_done = (timer_q == div_shadow_q - 16'd1);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    div_shadow_d = div_shadow_q;
    timer_d      = bit_done ? 16'd0 : timer_q + 16'd1;
    pop          = 1'b0;
    tx_d         = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      IDLE: begin
        timer_d = 16'd0;
        if (!empty) begin
          pop          = 1'b1;
          shift_d      = fifo_mem[rd_ptr_q];
          div_shadow_d = div_q;
          bit_cnt_d    = 3'd0;
          state_d      = START;
`ifdef UART_TX_PARITY_EN
          parity_d     = ^fifo_mem[rd_ptr_q];
`endif
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_cnt_q == 3'd7) state_d = PARITY;
`else
          if (bit_cnt_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the pin never glitches.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= 8'd0;
      bit_cnt_q    <= 3'd0;
      timer_q      <= 16'd0;
      div_shadow_q <= DIV_RESET;
      tx_q         <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      timer_q      <= timer_d;
      div_shadow_q <= div_shadow_d;
      tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign tx = tx_q;

  // ---------------------------------------------------------------- read path
  logic [15:0] status;
  logic [15:0] rd_val;
  logic [15:0] rd_data;
  logic [4:0]  count_field;

  assign count_field = 5'(count_q);
  assign status = {6'b0, PARITY_CAP, count_field, ovf_q, busy, empty, full};

  always_comb begin
    rd_val = 16'h0000;
    case (reg_sel)
      2'd1:    rd_val = status;
      2'd2:    rd_val = div_q;
      default: rd_val = 16'h0000;
    endcase
    if (wide)      rd_data = rd_val;
    else if (lane) rd_data = {8'h00, rd_val[15:8]};
    else           rd_data = {8'h00, rd_val[7:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout  <= 16'h0000;
      sel_q <= 1'b0;
    end else begin
      sel_q <= hit;
      if (hit && !wr) dout <= rd_data;
    end
  end

endmodule
